// File: rtl/radiant_trig_pkg.sv
// radiant_trig_pkg: state type shared by the trigger-line blocks
package radiant_trig_pkg;

    typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF} trig_gen_state_t;

endpackage

// File: rtl/radiant_trig_dncount.sv
// radiant_trig_dncount: loadable down-counter that stops at zero
module radiant_trig_dncount #(
    parameter int BITS = 8
) (
    input  logic            fast_clk_i,
    input  logic            rst_i,
    input  logic            load,
    input  logic [BITS-1:0] load_val,
    input  logic            ce,
    output logic            zero
);

    logic [BITS-1:0] count;

    assign zero = count == '0;

    always_ff @(posedge fast_clk_i or posedge rst_i) begin
        if (rst_i)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (ce && !zero)
            count <= count - BITS'(1);
    end

endmodule

// File: rtl/radiant_trig_pulse_gen.sv
// radiant_trig_pulse_gen: trigger-line transmitter, width/holdoff pulse shaper with drop flag and pulse count
module radiant_trig_pulse_gen
    import radiant_trig_pkg::*;
#(
    parameter int WIDTH_BITS   = 8,
    parameter int HOLDOFF_BITS = 16,
    parameter int COUNT_BITS   = 16,
    parameter bit INVERT       = 1'b0
) (
    input  logic                    fast_clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic                    trig_i,
    input  logic                    force_i,
    input  logic [WIDTH_BITS-1:0]   width_i,
    input  logic [HOLDOFF_BITS-1:0] holdoff_i,
    input  logic                    count_clr_i,
    output logic                    trig_o,
    output logic                    busy_o,
    output logic                    dropped_o,
    output logic [COUNT_BITS-1:0]   pulse_count_o
);

    trig_gen_state_t       state;
    logic                  req, w_load, h_ce, w_zero, h_zero, first;
    logic [WIDTH_BITS-1:0] w_init;

    assign req    = enable_i & (trig_i | force_i);
    assign w_load = state == IDLE && req;
    assign w_init = (width_i == '0) ? '0 : width_i - WIDTH_BITS'(1);
    // holdoff counter holds H through the pulse and starts counting on its last cycle
    assign h_ce   = (state == PULSE && w_zero) || state == HOLDOFF;

    radiant_trig_dncount #(.BITS(WIDTH_BITS)) u_width (
        .fast_clk_i (fast_clk_i),
        .rst_i      (rst_i),
        .load       (w_load),
        .load_val   (w_init),
        .ce         (state == PULSE),
        .zero       (w_zero)
    );

    radiant_trig_dncount #(.BITS(HOLDOFF_BITS)) u_holdoff (
        .fast_clk_i (fast_clk_i),
        .rst_i      (rst_i),
        .load       (w_load),
        .load_val   (holdoff_i),
        .ce         (h_ce),
        .zero       (h_zero)
    );

    always_ff @(posedge fast_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            trig_o        <= INVERT;
            busy_o        <= 1'b0;
            dropped_o     <= 1'b0;
            first         <= 1'b0;
            pulse_count_o <= '0;
        end else begin
            dropped_o     <= req && state != IDLE;
            first         <= w_load;
            pulse_count_o <= count_clr_i ? '0 : pulse_count_o + COUNT_BITS'(first);
            case (state)
                IDLE: if (req) begin
                    state  <= PULSE;
                    trig_o <= ~INVERT;
                    busy_o <= 1'b1;
                end
                PULSE: if (w_zero) begin
                    trig_o <= INVERT;
                    state  <= h_zero ? IDLE : HOLDOFF;
                    busy_o <= !h_zero;
                end
                HOLDOFF: if (h_zero) begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_radiant_trig_pulse_gen.sv
// tb_radiant_trig_pulse_gen: interval-based reference model plus directed literal checks, normal and inverted/4-bit-count instances
module tb_radiant_trig_pulse_gen;

    logic        fast_clk_i = 1'b0;
    logic        rst_i = 1'b1, enable_i = 1'b1, trig_i = 1'b0, force_i = 1'b0, count_clr_i = 1'b0;
    logic [7:0]  width_i = 8'd4;
    logic [15:0] holdoff_i = 16'd0;
    logic        trig_o, busy_o, dropped_o, trig_b, busy_b, drop_b;
    logic [15:0] pulse_count_o;
    logic [3:0]  cnt_b;

    int n_checks = 0, n_errors = 0;
    // model: pulse occupies cycles [m_start, m_pend], busy through m_bend
    int m_cyc = 0, m_start = -100, m_pend = -100, m_bend = -100, m_cnt = 0;
    bit m_drop = 1'b0;

    radiant_trig_pulse_gen u_dut (
        .fast_clk_i (fast_clk_i), .rst_i (rst_i), .enable_i (enable_i), .trig_i (trig_i),
        .force_i (force_i), .width_i (width_i), .holdoff_i (holdoff_i), .count_clr_i (count_clr_i),
        .trig_o (trig_o), .busy_o (busy_o), .dropped_o (dropped_o), .pulse_count_o (pulse_count_o)
    );

    radiant_trig_pulse_gen #(.COUNT_BITS(4), .INVERT(1'b1)) u_inv (
        .fast_clk_i (fast_clk_i), .rst_i (rst_i), .enable_i (enable_i), .trig_i (trig_i),
        .force_i (force_i), .width_i (width_i), .holdoff_i (holdoff_i), .count_clr_i (count_clr_i),
        .trig_o (trig_b), .busy_o (busy_b), .dropped_o (drop_b), .pulse_count_o (cnt_b)
    );

    always #5 fast_clk_i = ~fast_clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge fast_clk_i) begin
        bit req, busy_now;
        if (rst_i) begin
            m_start = -100; m_pend = -100; m_bend = -100; m_cnt = 0; m_drop = 1'b0;
        end else begin
            req      = enable_i && (trig_i || force_i);
            busy_now = m_cyc >= m_start && m_cyc <= m_bend;
            m_drop   = req && busy_now;
            if (count_clr_i) m_cnt = 0;
            else if (m_cyc == m_start) m_cnt++;
            if (req && !busy_now) begin
                m_start = m_cyc + 1;
                m_pend  = m_cyc + ((width_i == 0) ? 1 : int'(width_i));
                m_bend  = m_pend + int'(holdoff_i);
            end
        end
        m_cyc++;
    end

    always @(negedge fast_clk_i) begin
        bit e_trig, e_busy;
        if (rst_i) begin
            chk("rst trig", 32'(trig_o), 0);
            chk("rst trig_inv", 32'(trig_b), 1);
            chk("rst busy", 32'(busy_o), 0);
            chk("rst drop", 32'(dropped_o), 0);
            chk("rst cnt", 32'(pulse_count_o), 0);
            chk("rst cnt_b", 32'(cnt_b), 0);
        end else begin
            e_trig = m_cyc >= m_start && m_cyc <= m_pend;
            e_busy = m_cyc >= m_start && m_cyc <= m_bend;
            chk("model trig", 32'(trig_o), 32'(e_trig));
            chk("model trig_inv", 32'(trig_b), 32'(!e_trig));
            chk("model busy", 32'(busy_o), 32'(e_busy));
            chk("model busy_b", 32'(busy_b), 32'(e_busy));
            chk("model drop", 32'(dropped_o), 32'(m_drop));
            chk("model drop_b", 32'(drop_b), 32'(m_drop));
            chk("model cnt", 32'(pulse_count_o), 32'(m_cnt % 65536));
            chk("model cnt_b", 32'(cnt_b), 32'(m_cnt % 16));
        end
    end

    task automatic tick();
        @(posedge fast_clk_i);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic run(input int n, output int hi, output int bz, output int dr);
        hi = 0; bz = 0; dr = 0;
        repeat (n) begin
            tick();
            trig_i  = 1'b0;
            force_i = 1'b0;
            hi += int'(trig_o);
            bz += int'(busy_o);
            dr += int'(dropped_o);
        end
    endtask

    initial begin
        int h1, b1, d1, h2, b2, d2;
        logic [9:0]  pt, pb, pd;
        logic [19:0] pat;
        logic [15:0] c0, dc;
        ticks(3);
        chk("reset trig_inv", 32'(trig_b), 1);
        chk("reset cnt", 32'(pulse_count_o), 0);
        rst_i = 1'b0;
        ticks(3);
        // basic pulse: width 4, holdoff 0
        trig_i = 1'b1;
        tick();
        trig_i = 1'b0;
        chk("basic c1 trig", 32'(trig_o), 1);
        chk("basic c1 busy", 32'(busy_o), 1);
        chk("basic c1 trig_inv", 32'(trig_b), 0);
        chk("basic c1 cnt", 32'(pulse_count_o), 0);
        tick();
        chk("basic c2 cnt", 32'(pulse_count_o), 1);
        ticks(2);
        chk("basic c4 trig", 32'(trig_o), 1);
        tick();
        chk("basic c5 trig", 32'(trig_o), 0);
        chk("basic c5 busy", 32'(busy_o), 0);
        ticks(3);
        // width 0 behaves as 1
        width_i = 8'd0; trig_i = 1'b1;
        run(4, h1, b1, d1);
        chk("width0 len", h1, 1);
        ticks(2);
        // width latched at the request edge
        width_i = 8'd5; trig_i = 1'b1;
        run(2, h1, b1, d1);
        width_i = 8'd2;
        run(6, h2, b2, d2);
        chk("latch len", h1 + h2, 5);
        ticks(2);
        // holdoff and drop
        width_i = 8'd2; holdoff_i = 16'd3; trig_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            trig_i = (i == 3 || i == 6);
            pt[i-1] = trig_o; pb[i-1] = busy_o; pd[i-1] = dropped_o;
        end
        chk("holdoff trig pattern", 32'(pt), 32'h0C3);
        chk("holdoff busy pattern", 32'(pb), 32'h3DF);
        chk("holdoff drop pattern", 32'(pd), 32'h008);
        ticks(4);
        holdoff_i = 16'd0;
        // continuous request: 3 on / 1 off
        width_i = 8'd3; c0 = pulse_count_o; d1 = 0; trig_i = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 20) trig_i = 1'b0;
            pat[i-1] = trig_o;
            d1 += int'(dropped_o);
        end
        dc = pulse_count_o - c0;
        chk("continuous pattern", 32'(pat), 32'h77777);
        chk("continuous drops", d1, 15);
        chk("continuous count", 32'(dc), 5);
        ticks(2);
        // enable / force
        enable_i = 1'b0; force_i = 1'b1;
        run(4, h1, b1, d1);
        chk("disabled force pulse", h1, 0);
        chk("disabled force drop", d1, 0);
        enable_i = 1'b1; force_i = 1'b1;
        run(5, h1, b1, d1);
        chk("force pulse len", h1, 3);
        width_i = 8'd4; holdoff_i = 16'd2; force_i = 1'b1;
        run(2, h1, b1, d1);
        enable_i = 1'b0;
        run(8, h2, b2, d2);
        chk("enable drop pulse len", h1 + h2, 4);
        chk("enable drop busy len", b1 + b2, 6);
        enable_i = 1'b1; holdoff_i = 16'd0;
        ticks(2);
        // clear beats simultaneous increment
        width_i = 8'd2; trig_i = 1'b1;
        tick();
        trig_i = 1'b0; count_clr_i = 1'b1;
        tick();
        count_clr_i = 1'b0;
        chk("clear vs inc c2", 32'(pulse_count_o), 0);
        tick();
        chk("clear vs inc c3", 32'(pulse_count_o), 0);
        ticks(2);
        // wrap on the 4-bit counter instance
        width_i = 8'd0; count_clr_i = 1'b1;
        tick();
        count_clr_i = 1'b0; trig_i = 1'b1;
        for (int i = 1; i <= 30; i++) tick();
        trig_i = 1'b0;
        chk("wrap cnt_b 15", 32'(cnt_b), 15);
        trig_i = 1'b1;
        tick();
        trig_i = 1'b0;
        tick();
        chk("wrap cnt_b 0", 32'(cnt_b), 0);
        chk("wrap cnt 16", 32'(pulse_count_o), 16);
        ticks(2);
        // async reset mid-pulse
        width_i = 8'd8; trig_i = 1'b1;
        tick();
        trig_i = 1'b0;
        tick();
        chk("pre-reset trig", 32'(trig_o), 1);
        #1 rst_i = 1'b1;
        #1;
        chk("async rst trig", 32'(trig_o), 0);
        chk("async rst trig_inv", 32'(trig_b), 1);
        chk("async rst busy", 32'(busy_o), 0);
        tick();
        rst_i = 1'b0;
        ticks(2);
        width_i = 8'd3; trig_i = 1'b1;
        run(6, h1, b1, d1);
        chk("post-reset pulse len", h1, 3);
        chk("post-reset cnt", 32'(pulse_count_o), 1);
        ticks(3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
